// File: rtl/scoreboard_warp.sv
// Four-entry issue scoreboard: tracks in-flight destinations and replayable memory ops,
// flags RAW/WAW and memory-ordering hazards for the instruction at the IBuffer head.
module scoreboard_warp (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Src1_IB_Scb,
  input  logic [4:0] Src2_IB_Scb,
  input  logic [4:0] Dst_IB_Scb,
  input  logic       Src1_Valid_IB_Scb,
  input  logic       Src2_Valid_IB_Scb,
  input  logic       Dst_Valid_IB_Scb,
  input  logic       RP_Grt_IB_Scb,
  input  logic       Replayable_IB_Scb,
  input  logic       Replay_Complete_IB_Scb,
  input  logic [1:0] Replay_Complete_ScbID_IB_Scb,
  input  logic       Replay_SW_LWbar_IB_Scb,
  input  logic       Clear_Valid_WB_Scb,
  input  logic [1:0] Clear_ScbID_WB_Scb,
  output logic       Full_Scb_IB,
  output logic       Empty_Scb_IB,
  output logic       Dependent_Scb_IB,
  output logic [1:0] ScbID_Scb_IB
);

  localparam int unsigned NUM_ENTRIES = 4;
  localparam int unsigned ID_W        = 2;
  localparam int unsigned REG_W       = 5;

  logic [NUM_ENTRIES-1:0] valid;
  logic [NUM_ENTRIES-1:0] dst_valid;
  logic [NUM_ENTRIES-1:0] replayable;
  logic [NUM_ENTRIES-1:0] complete;
  logic [REG_W-1:0]       dst [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] rc_hit;
  logic [NUM_ENTRIES-1:0] wb_hit;
  logic [NUM_ENTRIES-1:0] alloc;
  logic [NUM_ENTRIES-1:0] free;
  logic [NUM_ENTRIES-1:0] complete_set;

  // Status outputs, all derived from registered state and current IB inputs
  always_comb begin
    Full_Scb_IB      = &valid;
    Empty_Scb_IB     = ~|valid;
    ScbID_Scb_IB     = '0;
    Dependent_Scb_IB = 1'b0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (!valid[i]) ScbID_Scb_IB = ID_W'(i);
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid[i] && dst_valid[i] &&
          ((Src1_Valid_IB_Scb && (dst[i] == Src1_IB_Scb)) ||
           (Src2_Valid_IB_Scb && (dst[i] == Src2_IB_Scb)) ||
           (Dst_Valid_IB_Scb  && (dst[i] == Dst_IB_Scb))))
        Dependent_Scb_IB = 1'b1;
      if (Replayable_IB_Scb && valid[i] && replayable[i] && !complete[i])
        Dependent_Scb_IB = 1'b1;
    end
  end

  // Per-entry event decode; events naming an invalid entry are dropped here
  always_comb begin
    rc_hit = '0;
    wb_hit = '0;
    alloc  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      rc_hit[i] = Replay_Complete_IB_Scb && (Replay_Complete_ScbID_IB_Scb == ID_W'(i)) && valid[i];
      wb_hit[i] = Clear_Valid_WB_Scb && (Clear_ScbID_WB_Scb == ID_W'(i)) && valid[i];
      alloc[i]  = RP_Grt_IB_Scb && !Full_Scb_IB && (ScbID_Scb_IB == ID_W'(i));
    end
  end

  // A writeback frees only once the load data is complete, including a replay finishing this cycle
  assign complete_set = rc_hit & {NUM_ENTRIES{~Replay_SW_LWbar_IB_Scb}};
  assign free         = (rc_hit & {NUM_ENTRIES{Replay_SW_LWbar_IB_Scb}}) |
                        (wb_hit & (complete | complete_set));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid      <= '0;
      dst_valid  <= '0;
      replayable <= '0;
      complete   <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) dst[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (alloc[i]) begin
          valid[i]      <= 1'b1;
          dst[i]        <= Dst_IB_Scb;
          dst_valid[i]  <= Dst_Valid_IB_Scb;
          replayable[i] <= Replayable_IB_Scb;
          complete[i]   <= ~Replayable_IB_Scb;
        end else begin
          if (free[i])         valid[i]    <= 1'b0;
          if (complete_set[i]) complete[i] <= 1'b1;
        end
      end
    end
  end

endmodule
